alu_btn_ctrl: RTL

Sequencer between the board push-buttons/switches and the shared 4-bit ALU datapath. It debounces the buttons and turns them into one-cycle pulses. It keeps the selected ALU opcode, latches the operands from the switches, and drives them onto the ALU for one settle cycle. It then captures the result and flags into registers that feed the seven-segment display path.

---
 rtl/alu_btn_if.sv | 23 ++
 rtl/alu_btn_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_btn_if.sv
// ALU datapath bus: operands/opcode out to the shared 4-bit ALU, result/flags back.
// The sequencer uses the master side; the ALU (or a model of it) uses the slave side.
interface alu_btn_if #(
  parameter int W = 4
);
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         alu_overflow;
  logic         alu_carry;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_zero, alu_overflow, alu_carry
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_zero, alu_overflow, alu_carry
  );
endinterface

// File: rtl/alu_btn_ctrl.sv
// Button/switch sequencer for the shared ALU: debounces buttons into one-cycle pulses,
// selects the opcode, launches an operation with latched operands and captures the result.
module alu_btn_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int W          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_next,
  input  logic            btn_prev,
  input  logic            btn_exec,
  input  logic            btn_clear,
  input  logic [2*W-1:0]  sw,
  alu_btn_if.master       alu,
  output logic [W-1:0]    res,
  output logic [2:0]      res_flags,
  output logic            res_valid,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  // Handshake: there is no valid/ready pair here. A debounced button pulse is a
  // one-cycle request that is either consumed on that edge or dropped; the ALU is
  // given exactly one settle cycle (SETUP) and its outputs are sampled on the next edge.

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int NB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Button index order: 0 next, 1 prev, 2 exec, 3 clear
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_q;
  logic [NB-1:0] pulse;
  logic [CW-1:0] cnt [NB];

  assign raw = {btn_clear, btn_exec, btn_prev, btn_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          // The increment that would reach DEB_CYCLES flips the level instead.
          if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign pulse = deb & ~deb_q;

  // Priority resolution: clear > exec > next/prev.
  logic p_clear;
  logic p_exec;
  logic p_next;
  logic p_prev;

  assign p_clear = pulse[3];
  assign p_exec  = pulse[2] & ~p_clear;
  assign p_next  = pulse[0] & ~p_clear & ~pulse[2];
  assign p_prev  = pulse[1] & ~p_clear & ~pulse[2];

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_r;
  logic [W-1:0]   a_nxt;
  logic [W-1:0]   b_r;
  logic [W-1:0]   b_nxt;
  logic [2:0]     op_r;
  logic [2:0]     op_nxt;
  logic [W-1:0]   res_r;
  logic [W-1:0]   res_nxt;
  logic [2:0]     flags_r;
  logic [2:0]     flags_nxt;
  logic           valid_r;
  logic           valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      res_r   <= '0;
      flags_r <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      op_r    <= op_nxt;
      res_r   <= res_nxt;
      flags_r <= flags_nxt;
      valid_r <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    b_nxt     = b_r;
    op_nxt    = op_r;
    res_nxt   = res_r;
    flags_nxt = flags_r;
    valid_nxt = valid_r;

    if (p_clear) begin
      // Discards any operation in flight; operands are left as they were.
      state_nxt = S_IDLE;
      op_nxt    = '0;
      res_nxt   = '0;
      flags_nxt = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        S_SETUP: begin
          res_nxt   = alu.alu_out;
          flags_nxt = {alu.alu_zero, alu.alu_overflow, alu.alu_carry};
          valid_nxt = 1'b1;
          state_nxt = S_HOLD;
        end
        default: begin
          if (p_exec) begin
            a_nxt     = sw[2*W-1:W];
            b_nxt     = sw[W-1:0];
            valid_nxt = 1'b0;
            state_nxt = S_SETUP;
          end else if (p_next ^ p_prev) begin
            // Any opcode change makes a held result stale.
            op_nxt    = p_next ? op_r + 3'd1 : op_r - 3'd1;
            valid_nxt = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  assign alu.alu_a  = a_r;
  assign alu.alu_b  = b_r;
  assign alu.alu_op = op_r;
  assign res        = res_r;
  assign res_flags  = flags_r;
  assign res_valid  = valid_r;
  assign busy       = (state == S_SETUP);
  assign state_dbg  = state;

endmodule
